// File: rtl/beep_pattern_scheduler_pkg.sv
// Shared constants and types for the beep pattern scheduler.
package beep_pattern_scheduler_pkg;

    localparam int unsigned COUNT_W          = 3;
    localparam int unsigned BEEPS_W          = 4;
    localparam int unsigned COUNT_ZERO_BEEPS = 8;
    localparam int unsigned DEFAULT_TICKS    = 32'd4999999;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // A requested count of zero stands for the maximum burst length.
    function automatic logic [BEEPS_W-1:0] decode_count(input logic [COUNT_W-1:0] c);
        return (c == '0) ? BEEPS_W'(COUNT_ZERO_BEEPS) : BEEPS_W'(c);
    endfunction

endpackage

// File: rtl/beep_pattern_scheduler_rr_arbiter.sv
// Round-robin grant selection: first pending requester at or after rr_ptr.
module beep_pattern_scheduler_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [IDX_W-1:0]   grant_idx_c,
    output logic               any_c
);

    logic [31:0] idx;

    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        any_c       = 1'b0;
        idx         = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any_c && req_valid[idx[IDX_W-1:0]]) begin
                any_c       = 1'b1;
                grant_idx_c = idx[IDX_W-1:0];
            end
        end
        if (any_c) begin
            grant_c = NUM_REQ'(1) << grant_idx_c;
        end
    end

endmodule

// File: rtl/beep_pattern_scheduler.sv
// Shares one tone generator among requesters, timing beep bursts and gaps.
module beep_pattern_scheduler
    import beep_pattern_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned BEEP_TICKS = DEFAULT_TICKS,
    parameter int unsigned GAP_TICKS  = DEFAULT_TICKS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [COUNT_W*NUM_REQ-1:0] req_count,
    input  logic [NUM_REQ-1:0]         req_tone,
    input  logic                       abort,
    input  logic                       mute,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic [NUM_REQ-1:0]         req_done,
    output logic                       busy,
    output logic                       wave_in,
    output logic                       wave_enable,
    output logic                       wave_freq_sel
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state, state_n;
    logic [CNT_W-1:0]   timer, timer_n;
    logic [BEEPS_W-1:0] beeps_left, beeps_n;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_n;
    logic [IDX_W-1:0]   gidx, gidx_n;
    logic               tone, tone_n;
    logic [NUM_REQ-1:0] ack_n, done_n;

    logic [NUM_REQ-1:0] grant_c;
    logic [IDX_W-1:0]   grant_idx_c;
    logic               any_c;

    beep_pattern_scheduler_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req_valid   (req_valid),
        .rr_ptr      (rr_ptr),
        .grant_c     (grant_c),
        .grant_idx_c (grant_idx_c),
        .any_c       (any_c)
    );

    // Next-state and sequencing decisions; abort always wins over expiry.
    always_comb begin
        state_n  = state;
        timer_n  = timer;
        beeps_n  = beeps_left;
        rr_ptr_n = rr_ptr;
        gidx_n   = gidx;
        tone_n   = tone;
        ack_n    = '0;
        done_n   = '0;
        unique case (state)
            ST_IDLE: begin
                if (!abort && any_c) begin
                    gidx_n   = grant_idx_c;
                    tone_n   = req_tone[grant_idx_c];
                    beeps_n  = decode_count(req_count[32'(grant_idx_c)*COUNT_W +: COUNT_W]);
                    timer_n  = CNT_W'(BEEP_TICKS);
                    rr_ptr_n = (32'(grant_idx_c) == NUM_REQ - 1) ? '0 : grant_idx_c + IDX_W'(1);
                    ack_n    = grant_c;
                    state_n  = ST_ON;
                end
            end
            ST_ON: begin
                if (abort) begin
                    state_n = ST_IDLE;
                end else if (timer == '0) begin
                    beeps_n = beeps_left - BEEPS_W'(1);
                    if (beeps_left == BEEPS_W'(1)) begin
                        state_n = ST_IDLE;
                        done_n  = NUM_REQ'(1) << gidx;
                    end else begin
                        state_n = ST_GAP;
                        timer_n = CNT_W'(GAP_TICKS);
                    end
                end else begin
                    timer_n = timer - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_n = ST_IDLE;
                end else if (timer == '0) begin
                    state_n = ST_ON;
                    timer_n = CNT_W'(BEEP_TICKS);
                end else begin
                    timer_n = timer - CNT_W'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, timers and all outputs registered from the next-state view.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            timer         <= '0;
            beeps_left    <= '0;
            rr_ptr        <= '0;
            gidx          <= '0;
            tone          <= 1'b0;
            req_ack       <= '0;
            req_done      <= '0;
            busy          <= 1'b0;
            wave_in       <= 1'b0;
            wave_enable   <= 1'b0;
            wave_freq_sel <= 1'b0;
        end else begin
            state         <= state_n;
            timer         <= timer_n;
            beeps_left    <= beeps_n;
            rr_ptr        <= rr_ptr_n;
            gidx          <= gidx_n;
            tone          <= tone_n;
            req_ack       <= ack_n;
            req_done      <= done_n;
            busy          <= (state_n != ST_IDLE);
            wave_in       <= (state_n == ST_ON);
            wave_enable   <= (state_n == ST_ON) && !mute;
            wave_freq_sel <= (state_n != ST_IDLE) && tone_n;
        end
    end

endmodule

// File: tb/tb_beep_pattern_scheduler.sv
// Directed bench for beep_pattern_scheduler with short beep/gap intervals.
module tb_beep_pattern_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [11:0] req_count;
    logic [3:0]  req_tone;
    logic        abort;
    logic        mute;
    logic [3:0]  req_ack;
    logic [3:0]  req_done;
    logic        busy;
    logic        wave_in;
    logic        wave_enable;
    logic        wave_freq_sel;

    int total = 0;
    int bad   = 0;

    beep_pattern_scheduler #(
        .NUM_REQ    (4),
        .CNT_W      (32),
        .BEEP_TICKS (3),
        .GAP_TICKS  (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_count     (req_count),
        .req_tone      (req_tone),
        .abort         (abort),
        .mute          (mute),
        .req_ack       (req_ack),
        .req_done      (req_done),
        .busy          (busy),
        .wave_in       (wave_in),
        .wave_enable   (wave_enable),
        .wave_freq_sel (wave_freq_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_count = '0;
        req_tone  = '0;
        abort     = 1'b0;
        mute      = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Requester 0, two beeps at tone 1; used with and without mute.
    task automatic two_beep_seq(input logic m, input string pfx);
        logic exp_on;
        do_reset();
        mute      = m;
        req_valid = 4'b0001;
        req_count = 12'h002;
        req_tone  = 4'b0001;
        tick();
        req_valid = '0;
        for (int c = 1; c <= 12; c++) begin
            exp_on = (c <= 4) || (c >= 8 && c <= 11);
            chk($sformatf("%s_wave_in_c%0d", pfx, c), 32'(wave_in), 32'(exp_on));
            chk($sformatf("%s_wave_en_c%0d", pfx, c), 32'(wave_enable), 32'(exp_on && !m));
            chk($sformatf("%s_busy_c%0d", pfx, c), 32'(busy), 32'(c <= 11));
            chk($sformatf("%s_fsel_c%0d", pfx, c), 32'(wave_freq_sel), 32'(c <= 11));
            chk($sformatf("%s_ack_c%0d", pfx, c), 32'(req_ack), (c == 1) ? 32'h1 : 32'h0);
            chk($sformatf("%s_done_c%0d", pfx, c), 32'(req_done), (c == 12) ? 32'h1 : 32'h0);
            tick();
        end
        mute = 1'b0;
    endtask

    initial begin
        int   on_cnt;
        int   rises;
        int   busy_cnt;
        int   done_cyc;
        logic [3:0] done_val;
        logic prev;
        int   p;
        int   k;

        rst_n     = 1'b0;
        req_valid = '0;
        req_count = '0;
        req_tone  = '0;
        abort     = 1'b0;
        mute      = 1'b0;
        #2;
        chk("rst_ack", 32'(req_ack), 32'h0);
        chk("rst_done", 32'(req_done), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_wave_in", 32'(wave_in), 32'h0);
        chk("rst_wave_en", 32'(wave_enable), 32'h0);
        chk("rst_fsel", 32'(wave_freq_sel), 32'h0);

        // Single requester, two beeps, audible.
        two_beep_seq(1'b0, "s1");

        // Two requesters held, one beep each: grants alternate 0,2,0,2.
        do_reset();
        req_valid = 4'b0101;
        req_count = 12'b001_001_001_001;
        req_tone  = 4'b0000;
        tick();
        for (int c = 1; c <= 20; c++) begin
            p = (c - 1) % 5;
            k = (c - 1) / 5;
            chk($sformatf("s2_wave_in_c%0d", c), 32'(wave_in), 32'(p <= 3));
            chk($sformatf("s2_ack_c%0d", c), 32'(req_ack),
                (p == 0) ? ((k % 2 == 0) ? 32'h1 : 32'h4) : 32'h0);
            chk($sformatf("s2_done_c%0d", c), 32'(req_done),
                (p == 4) ? ((k % 2 == 0) ? 32'h1 : 32'h4) : 32'h0);
            if (c == 20) req_valid = '0;
            tick();
        end
        chk("s2_idle_busy", 32'(busy), 32'h0);
        chk("s2_idle_ack", 32'(req_ack), 32'h0);

        // Count 0 on requester 1 means eight beeps.
        do_reset();
        req_valid = 4'b0010;
        req_count = 12'h000;
        req_tone  = 4'b0000;
        tick();
        req_valid = '0;
        chk("s3_ack", 32'(req_ack), 32'h2);
        on_cnt = 0; rises = 0; busy_cnt = 0; done_cyc = 0; done_val = '0; prev = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (wave_in) on_cnt++;
            if (wave_in && !prev) rises++;
            prev = wave_in;
            if (busy) busy_cnt++;
            if (req_done != '0) begin
                done_cyc = c;
                done_val = req_done;
            end
            tick();
        end
        chk("s3_on_cycles", 32'(on_cnt), 32'd32);
        chk("s3_bursts", 32'(rises), 32'd8);
        chk("s3_busy_cycles", 32'(busy_cnt), 32'd53);
        chk("s3_done_cycle", 32'(done_cyc), 32'd54);
        chk("s3_done_val", 32'(done_val), 32'h2);

        // Abort on the 2nd ON cycle of beep 2 of 3, requester 3 pending.
        do_reset();
        req_valid = 4'b1001;
        req_count = 12'b001_000_000_011;
        req_tone  = 4'b0001;
        tick();
        req_valid = 4'b1000;
        chk("s4_ack0", 32'(req_ack), 32'h1);
        for (int c = 1; c < 9; c++) tick();
        chk("s4_on_at_abort", 32'(wave_in), 32'h1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("s4_wave_in", 32'(wave_in), 32'h0);
        chk("s4_wave_en", 32'(wave_enable), 32'h0);
        chk("s4_fsel", 32'(wave_freq_sel), 32'h0);
        chk("s4_busy", 32'(busy), 32'h0);
        chk("s4_done_c10", 32'(req_done), 32'h0);
        chk("s4_ack_c10", 32'(req_ack), 32'h0);
        tick();
        req_valid = '0;
        chk("s4_ack3", 32'(req_ack), 32'h8);
        chk("s4_wave_in3", 32'(wave_in), 32'h1);
        chk("s4_fsel3", 32'(wave_freq_sel), 32'h0);
        for (int c = 11; c <= 14; c++) begin
            chk($sformatf("s4_done_c%0d", c), 32'(req_done), 32'h0);
            tick();
        end
        chk("s4_done3", 32'(req_done), 32'h8);

        // Muted sequence: identical timing, enable held low.
        two_beep_seq(1'b1, "s5");

        // Reset during GAP clears outputs at once and stays idle.
        do_reset();
        req_valid = 4'b0001;
        req_count = 12'h002;
        req_tone  = 4'b0001;
        tick();
        req_valid = '0;
        for (int c = 1; c < 5; c++) tick();
        chk("s6_pre_busy", 32'(busy), 32'h1);
        chk("s6_pre_gap", 32'(wave_in), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("s6_rst_busy", 32'(busy), 32'h0);
        chk("s6_rst_fsel", 32'(wave_freq_sel), 32'h0);
        chk("s6_rst_wave_in", 32'(wave_in), 32'h0);
        chk("s6_rst_ack", 32'(req_ack), 32'h0);
        chk("s6_rst_done", 32'(req_done), 32'h0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (c % 5 == 4) begin
                chk($sformatf("s6_post_busy_%0d", c), 32'(busy), 32'h0);
                chk($sformatf("s6_post_wave_%0d", c), 32'(wave_in), 32'h0);
            end
            chk($sformatf("s6_post_ack_%0d", c), 32'(req_ack), 32'h0);
            chk($sformatf("s6_post_done_%0d", c), 32'(req_done), 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
